// File: rtl/packet_struct_pkg.sv
// Shared packet-level widths and header layouts for the UDP receive path.
package packet_struct_pkg;

  localparam int unsigned IP_ADDR_W               = 32;
  localparam int unsigned TOT_LEN_W               = 16;
  localparam int unsigned PKT_TIMESTAMP_W         = 64;
  localparam int unsigned MAC_INTERFACE_W         = 256;
  // Wide enough to hold a full-line pad count (0..32).
  localparam int unsigned MAC_PADBYTES_W          = 6;
  localparam int unsigned CHKSUM_PSEUDO_HDR_BYTES = 12;
  localparam int unsigned UDP_HDR_BYTES           = 8;

  // IPv4 pseudo header as prepended by the checksum engine, MSB first on the line.
  typedef struct packed {
    logic [IP_ADDR_W-1:0] src_ip;
    logic [IP_ADDR_W-1:0] dst_ip;
    logic [7:0]           zeros;
    logic [7:0]           protocol;
    logic [TOT_LEN_W-1:0] udp_len;
  } chksum_pseudo_hdr;

  typedef struct packed {
    logic [PKT_TIMESTAMP_W-1:0] timestamp;
  } tracker_stats_struct;

endpackage

// File: rtl/udp_rx_chksum_output_ctrl.sv
// Strips the 12 B pseudo header off the checksum-engine stream, realigns the
// datagram onto line boundaries and pairs the final line with the checksum verdict.
module udp_rx_chksum_output_ctrl
  import packet_struct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = PKT_TIMESTAMP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resp_tval,
  input  logic [DATA_WIDTH-1:0]      resp_tdata,
  input  logic [DATA_WIDTH/8-1:0]    resp_tkeep,
  input  logic [USER_WIDTH-1:0]      resp_tuser,
  input  logic                       resp_tlast,
  output logic                       resp_trdy,
  input  logic                       resp_csum_val,
  input  logic [15:0]                resp_csum,
  output logic                       resp_csum_rdy,
  output logic                       chksum_dst_rx_hdr_val,
  output logic [IP_ADDR_W-1:0]       chksum_dst_rx_src_ip,
  output logic [IP_ADDR_W-1:0]       chksum_dst_rx_dst_ip,
  output logic [TOT_LEN_W-1:0]       chksum_dst_rx_udp_len,
  output tracker_stats_struct        chksum_dst_rx_timestamp,
  input  logic                       dst_chksum_rx_hdr_rdy,
  output logic                       chksum_dst_rx_data_val,
  output logic [MAC_INTERFACE_W-1:0] chksum_dst_rx_data,
  output logic                       chksum_dst_rx_last,
  output logic [MAC_PADBYTES_W-1:0]  chksum_dst_rx_padbytes,
  output logic                       chksum_dst_rx_chksum_ok,
  input  logic                       dst_chksum_rx_data_rdy
);

  localparam int unsigned KeepW     = DATA_WIDTH / 8;
  localparam int unsigned HdrBits   = $bits(chksum_pseudo_hdr);
  localparam int unsigned CarryBits = DATA_WIDTH - HdrBits;
  // UDP checksum is the last 16 bits of the UDP header, which starts right after the pseudo header.
  localparam int unsigned CsumLsb   = CarryBits - UDP_HDR_BYTES * 8;
  localparam int unsigned CntW      = $clog2(KeepW + 1);
  localparam logic [CntW-1:0] HdrCnt  = CntW'(CHKSUM_PSEUDO_HDR_BYTES);
  localparam logic [CntW-1:0] LineCnt = CntW'(KeepW);

  localparam logic [1:0] StFirst = 2'd0;
  localparam logic [1:0] StBody  = 2'd1;
  localparam logic [1:0] StTail  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CarryBits-1:0] carry_q, carry_d;
  logic [15:0]          csum_q, csum_d;
  logic [15:0]          field_q, field_d;
  logic [CntW-1:0]      valid_q, valid_d;
  logic                 have_q, have_d;

  logic [CntW-1:0]       keep_cnt, tail_cnt, pad;
  logic                  short_last, gate_ok, last_hs;
  logic                  hdr_val, data_val, trdy, last;
  logic [DATA_WIDTH-1:0] out_data;

  // Count valid bytes on the current input beat.
  always_comb begin
    keep_cnt = '0;
    for (int unsigned i = 0; i < KeepW; i++) begin
      keep_cnt = keep_cnt + CntW'(resp_tkeep[i]);
    end
  end

  assign short_last = resp_tlast && (keep_cnt <= HdrCnt);
  // Bytes of the new carry that belong to the datagram; clamped for malformed short beats.
  assign tail_cnt   = (keep_cnt > HdrCnt) ? keep_cnt - HdrCnt : '0;

  // Realignment FSM, output formation and checksum-result bookkeeping.
  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    csum_d   = csum_q;
    field_d  = field_q;
    valid_d  = valid_q;
    have_d   = have_q;
    hdr_val  = 1'b0;
    data_val = 1'b0;
    trdy     = 1'b0;
    last     = 1'b0;
    pad      = '0;
    last_hs  = 1'b0;
    gate_ok  = 1'b0;
    out_data = {carry_q, resp_tdata[DATA_WIDTH-1 -: HdrBits]};

    unique case (state_q)
      StFirst: begin
        hdr_val = resp_tval;
        trdy    = dst_chksum_rx_hdr_rdy;
        if (resp_tval && dst_chksum_rx_hdr_rdy) begin
          carry_d = resp_tdata[CarryBits-1:0];
          field_d = resp_tdata[CsumLsb +: 16];
          if (resp_tlast) begin
            valid_d = tail_cnt;
            state_d = StTail;
          end else begin
            state_d = StBody;
          end
        end
      end
      StBody: begin
        // A beat that closes the packet must wait for the checksum verdict.
        gate_ok  = !short_last || have_q;
        data_val = resp_tval && gate_ok;
        trdy     = dst_chksum_rx_data_rdy && gate_ok;
        if (short_last) begin
          last = 1'b1;
          pad  = HdrCnt - keep_cnt;
        end
        if (data_val && dst_chksum_rx_data_rdy) begin
          if (short_last) begin
            last_hs = 1'b1;
            state_d = StFirst;
          end else begin
            carry_d = resp_tdata[CarryBits-1:0];
            if (resp_tlast) begin
              valid_d = tail_cnt;
              state_d = StTail;
            end
          end
        end
      end
      StTail: begin
        out_data = {carry_q, {HdrBits{1'b0}}};
        data_val = have_q;
        last     = 1'b1;
        pad      = LineCnt - valid_q;
        if (have_q && dst_chksum_rx_data_rdy) begin
          last_hs = 1'b1;
          state_d = StFirst;
        end
      end
      default: state_d = StFirst;
    endcase

    if (resp_csum_val && !have_q) begin
      have_d = 1'b1;
      csum_d = resp_csum;
    end else if (last_hs) begin
      have_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any in-flight packet and pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFirst;
      carry_q <= '0;
      csum_q  <= '0;
      field_q <= '0;
      valid_q <= '0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      csum_q  <= csum_d;
      field_q <= field_d;
      valid_q <= valid_d;
      have_q  <= have_d;
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign resp_trdy              = trdy && rst;
  assign resp_csum_rdy          = !have_q && rst;
  assign chksum_dst_rx_hdr_val  = hdr_val && rst;
  assign chksum_dst_rx_data_val = data_val && rst;

  assign chksum_dst_rx_src_ip    = resp_tdata[DATA_WIDTH-1 -: IP_ADDR_W];
  assign chksum_dst_rx_dst_ip    = resp_tdata[DATA_WIDTH-1-IP_ADDR_W -: IP_ADDR_W];
  assign chksum_dst_rx_udp_len   = resp_tdata[CarryBits +: TOT_LEN_W];
  assign chksum_dst_rx_timestamp = tracker_stats_struct'(PKT_TIMESTAMP_W'(resp_tuser));

  assign chksum_dst_rx_data       = MAC_INTERFACE_W'(out_data);
  assign chksum_dst_rx_last       = last;
  assign chksum_dst_rx_padbytes   = MAC_PADBYTES_W'(pad);
  assign chksum_dst_rx_chksum_ok  = (csum_q == 16'hFFFF) || (field_q == 16'h0000);

endmodule

// File: tb/tb_udp_rx_chksum_output_ctrl.sv
// Randomized bench: packets are built as byte lists, the expected output lines are
// the datagram chopped into 32 B lines, and a single cycle loop drives and monitors.
module tb_udp_rx_chksum_output_ctrl;
  import packet_struct_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         resp_tval, resp_tlast, resp_trdy;
  logic [255:0] resp_tdata;
  logic [31:0]  resp_tkeep;
  logic [63:0]  resp_tuser;
  logic         resp_csum_val, resp_csum_rdy;
  logic [15:0]  resp_csum;
  logic         hdr_val, hdr_rdy, data_val, data_rdy, data_last, data_ok;
  logic [31:0]  src_ip, dst_ip;
  logic [15:0]  udp_len;
  tracker_stats_struct ts_out;
  logic [255:0] data_out;
  logic [5:0]   padbytes;

  udp_rx_chksum_output_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .resp_tval               (resp_tval),
    .resp_tdata              (resp_tdata),
    .resp_tkeep              (resp_tkeep),
    .resp_tuser              (resp_tuser),
    .resp_tlast              (resp_tlast),
    .resp_trdy               (resp_trdy),
    .resp_csum_val           (resp_csum_val),
    .resp_csum               (resp_csum),
    .resp_csum_rdy           (resp_csum_rdy),
    .chksum_dst_rx_hdr_val   (hdr_val),
    .chksum_dst_rx_src_ip    (src_ip),
    .chksum_dst_rx_dst_ip    (dst_ip),
    .chksum_dst_rx_udp_len   (udp_len),
    .chksum_dst_rx_timestamp (ts_out),
    .dst_chksum_rx_hdr_rdy   (hdr_rdy),
    .chksum_dst_rx_data_val  (data_val),
    .chksum_dst_rx_data      (data_out),
    .chksum_dst_rx_last      (data_last),
    .chksum_dst_rx_padbytes  (padbytes),
    .chksum_dst_rx_chksum_ok (data_ok),
    .dst_chksum_rx_data_rdy  (data_rdy)
  );

  typedef struct { logic [255:0] data; logic [31:0] keep; logic last; logic [63:0] user; } beat_t;
  typedef struct { logic [31:0] src; logic [31:0] dst; logic [15:0] len; logic [63:0] ts; } hdr_t;
  typedef struct { logic [255:0] data; int nbytes; logic last; int pad; logic ok; } line_t;
  typedef struct { logic [15:0] val; int delay; } csum_t;

  beat_t in_q[$];
  csum_t cs_q[$];
  hdr_t  hdr_q[$];
  line_t line_q[$];
  int    csum_acc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lines_out = 0;
  int cs_wait = 0;
  bit in_busy = 0;
  bit cs_busy = 0;
  bit hdr_pend = 0;
  bit data_pend = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Build one packet: input beats, expected header, expected output lines, checksum offer.
  task automatic add_pkt(input int len, input bit fld_zero, input logic [15:0] csum, input int delay);
    logic [7:0] st[$];
    logic [7:0] dg[$];
    hdr_t  h;
    beat_t b;
    line_t l;
    csum_t c;
    int    nb, nl;
    logic  ok;
    h.src = $urandom;
    h.dst = $urandom;
    h.len = 16'(len);
    h.ts  = {$urandom, $urandom};
    for (int i = 0; i < len; i++) dg.push_back(8'($urandom));
    if (fld_zero) begin
      dg[6] = 8'h00;
      dg[7] = 8'h00;
    end else begin
      dg[7] = dg[7] | 8'h01;
    end
    ok = (csum == 16'hFFFF) || ({dg[6], dg[7]} == 16'h0000);
    for (int i = 3; i >= 0; i--) st.push_back(h.src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) st.push_back(h.dst[8*i +: 8]);
    st.push_back(8'h00);
    st.push_back(8'h11);
    st.push_back(h.len[15:8]);
    st.push_back(h.len[7:0]);
    foreach (dg[i]) st.push_back(dg[i]);
    nb = (st.size() + 31) / 32;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 32; j++) begin
        if (32 * k + j < st.size()) begin
          b.data[255 - 8*j -: 8] = st[32*k + j];
          b.keep[31 - j] = 1'b1;
        end
      end
      b.last = (k == nb - 1);
      b.user = h.ts;
      in_q.push_back(b);
    end
    nl = (len + 31) / 32;
    for (int k = 0; k < nl; k++) begin
      l.data   = '0;
      l.nbytes = (len - 32*k > 32) ? 32 : len - 32*k;
      for (int j = 0; j < l.nbytes; j++) l.data[255 - 8*j -: 8] = dg[32*k + j];
      l.last = (k == nl - 1);
      l.pad  = l.last ? 32 - l.nbytes : 0;
      l.ok   = ok;
      line_q.push_back(l);
    end
    hdr_q.push_back(h);
    c.val   = csum;
    c.delay = delay;
    cs_q.push_back(c);
  endtask

  // One clock: called just after a falling edge, returns at the next falling edge.
  task automatic run_cycle(input bit bp);
    hdr_t  h;
    line_t l;
    logic [255:0] mask;
    if (!in_busy && in_q.size() > 0 && (!bp || $urandom_range(0, 3) != 0)) in_busy = 1;
    resp_tval  = in_busy;
    resp_tdata = in_busy ? in_q[0].data : '0;
    resp_tkeep = in_busy ? in_q[0].keep : '0;
    resp_tlast = in_busy ? in_q[0].last : 1'b0;
    resp_tuser = in_busy ? in_q[0].user : '0;
    if (!cs_busy && cs_q.size() > 0) begin
      if (cs_wait >= cs_q[0].delay) cs_busy = 1;
      else cs_wait++;
    end
    resp_csum_val = cs_busy;
    resp_csum     = cs_busy ? cs_q[0].val : '0;
    hdr_rdy  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    data_rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    if (hdr_pend) check_eq("hdr_val_hold", hdr_val, 1'b1);
    if (data_pend) check_eq("data_val_hold", data_val, 1'b1);
    if (hdr_val && hdr_rdy) begin
      check_eq("hdr_queued", hdr_q.size() > 0, 1'b1);
      if (hdr_q.size() > 0) begin
        h = hdr_q.pop_front();
        check_eq("hdr_src", src_ip, h.src);
        check_eq("hdr_dst", dst_ip, h.dst);
        check_eq("hdr_len", udp_len, h.len);
        check_eq("hdr_ts", ts_out.timestamp, h.ts);
      end
    end
    if (data_val && data_rdy) begin
      lines_out++;
      check_eq("data_queued", line_q.size() > 0, 1'b1);
      if (line_q.size() > 0) begin
        l = line_q.pop_front();
        mask = '1;
        mask = mask << (8 * (32 - l.nbytes));
        check_eq("data", data_out & mask, l.data);
        check_eq("last", data_last, l.last);
        check_eq("padbytes", padbytes, l.pad);
        if (l.last) begin
          check_eq("chksum_ok", data_ok, l.ok);
          check_eq("csum_before_last", (csum_acc_q.size() > 0) && (csum_acc_q[0] < cyc), 1'b1);
          if (csum_acc_q.size() > 0) void'(csum_acc_q.pop_front());
        end
      end
    end
    hdr_pend  = hdr_val && !hdr_rdy;
    data_pend = data_val && !data_rdy;
    if (resp_tval && resp_trdy) begin
      void'(in_q.pop_front());
      in_busy = 0;
    end
    if (resp_csum_val && resp_csum_rdy) begin
      csum_acc_q.push_back(cyc);
      void'(cs_q.pop_front());
      cs_busy = 0;
      cs_wait = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input bit bp, input int budget);
    int n = 0;
    while ((in_q.size() + cs_q.size() + hdr_q.size() + line_q.size()) != 0 && n < budget) begin
      run_cycle(bp);
      n++;
    end
    check_eq("drain_pending", in_q.size() + cs_q.size() + hdr_q.size() + line_q.size(), 0);
    repeat (3) run_cycle(bp);
  endtask

  // Hold reset with live upstream traffic offered; every handshake output must stay low.
  task automatic apply_reset();
    rst           = 1'b0;
    resp_tval     = 1'b1;
    resp_tdata    = {8{$urandom}};
    resp_tkeep    = '1;
    resp_tlast    = 1'b0;
    resp_tuser    = '0;
    resp_csum_val = 1'b1;
    resp_csum     = 16'hFFFF;
    hdr_rdy       = 1'b1;
    data_rdy      = 1'b1;
    #1;
    check_eq("rst_hdr_val", hdr_val, 1'b0);
    check_eq("rst_data_val", data_val, 1'b0);
    check_eq("rst_resp_trdy", resp_trdy, 1'b0);
    check_eq("rst_csum_rdy", resp_csum_rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    in_q.delete();
    cs_q.delete();
    hdr_q.delete();
    line_q.delete();
    csum_acc_q.delete();
    in_busy   = 0;
    cs_busy   = 0;
    cs_wait   = 0;
    hdr_pend  = 0;
    data_pend = 0;
    resp_tval     = 1'b0;
    resp_csum_val = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    resp_tval = 0; resp_tdata = '0; resp_tkeep = '0; resp_tuser = '0; resp_tlast = 0;
    resp_csum_val = 0; resp_csum = '0; hdr_rdy = 0; data_rdy = 0;
    @(negedge clk);
    apply_reset();
    @(negedge clk);

    // Two full lines, checksum offered early.
    add_pkt(64, 1'b0, 16'hFFFF, 0);
    drain(1'b0, 200);
    // Single short line, checksum arrives late so the last line must wait.
    add_pkt(28, 1'b0, 16'h1234, 40);
    drain(1'b0, 200);
    // Single input beat, emitted from the tail path.
    add_pkt(8, 1'b0, 16'h5A5A, 0);
    drain(1'b0, 200);
    // Checksum field zero in the header means checksum disabled.
    add_pkt(50, 1'b1, 16'hABCD, 5);
    drain(1'b0, 200);

    // Reset in the middle of a multi-line packet, then a clean packet.
    add_pkt(100, 1'b0, 16'hFFFF, 0);
    n = 0;
    while (lines_out == 0 && n < 200) begin
      run_cycle(1'b0);
      n++;
    end
    apply_reset();
    @(negedge clk);
    add_pkt(40, 1'b0, 16'hFFFF, 3);
    drain(1'b0, 200);

    // Random lengths, checksum timing and backpressure.
    for (int p = 0; p < 100; p++) begin
      add_pkt($urandom_range(8, 130), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
              $urandom_range(0, 12));
    end
    drain(1'b1, 20000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
